// File: rtl/note_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : note_sequencer_pkg                                         |
// | Description : Shared encodings, state type and helpers for the sequencer.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package note_sequencer_pkg;

  localparam int NUM_NOTES = 8;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_UPDOWN = 2'b10;

  localparam logic [1:0] DUR_FULL    = 2'b00;
  localparam logic [1:0] DUR_HALF    = 2'b01;
  localparam logic [1:0] DUR_QUARTER = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [2:0] dur_ticks(input logic [1:0] dur);
    logic [2:0] w_t;
    case (dur)
      DUR_FULL:    w_t = 3'd4;
      DUR_HALF:    w_t = 3'd2;
      DUR_QUARTER: w_t = 3'd1;
      default:     w_t = 3'd1;
    endcase
    return w_t;
  endfunction

  // The position counter always counts upward; direction lives in this mapping.
  function automatic logic [2:0] pos_to_idx(input logic [1:0] mode, input logic [3:0] pos);
    logic [3:0] w_v;
    case (mode)
      MODE_UP:     w_v = pos;
      MODE_DOWN:   w_v = 4'd7 - pos;
      MODE_UPDOWN: w_v = (pos < 4'd8) ? pos : 4'd14 - pos;
      default:     w_v = pos;
    endcase
    return w_v[2:0];
  endfunction

  function automatic logic [3:0] last_pos(input logic [1:0] mode);
    return (mode == MODE_UPDOWN) ? 4'd14 : 4'(NUM_NOTES - 1);
  endfunction

  function automatic logic [NUM_NOTES-1:0] onehot(input logic [2:0] idx);
    return 8'h80 >> idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : note_sequencer_tick_gen                                    |
// | Description : Free-running divider, one-cycle tick every TICK_DIV clocks.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module note_sequencer_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : note_sequencer                                             |
// | Description : Steps a note-enable mask through the octave on request.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BEAT_HZ    = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [1:0] dur_sel,
  output logic [7:0] note_en,
  output logic [2:0] note_idx,
  output logic       busy,
  output logic       done
);

  localparam int TICK_DIV = CLK_HZ / (4 * BEAT_HZ);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] C_GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        r_state;
  logic          r_start_d;
  logic [1:0]    r_mode;
  logic [1:0]    r_dur;
  logic [7:0]    r_sw;
  logic [3:0]    r_pos;
  logic [2:0]    r_ticks;
  logic [GW-1:0] r_gap;

  logic          w_tick;
  logic          w_clr;
  logic          w_start_edge;
  logic          w_note_end;
  logic          w_last;
  logic [3:0]    w_next_pos;
  logic [2:0]    w_next_idx;
  logic [2:0]    w_first_idx;

  assign w_start_edge = start & ~r_start_d;
  assign w_note_end   = (r_state == ST_PLAY) && w_tick && (r_ticks == dur_ticks(r_dur) - 3'd1);
  assign w_last       = (r_pos == last_pos(r_mode));
  assign w_next_pos   = r_pos + 4'd1;
  assign w_next_idx   = pos_to_idx(r_mode, w_next_pos);
  assign w_first_idx  = pos_to_idx(mode, 4'd0);
  // Divider is held at zero outside a note so every note starts on a fresh tick period.
  assign w_clr        = (r_state != ST_PLAY) || w_note_end;

  note_sequencer_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_start_d <= 1'b0;
      r_mode    <= MODE_UP;
      r_dur     <= DUR_FULL;
      r_sw      <= 8'h00;
      r_pos     <= 4'd0;
      r_ticks   <= 3'd0;
      r_gap     <= '0;
      note_en   <= 8'h00;
      note_idx  <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_start_d <= start;
      case (r_state)
        ST_IDLE: begin
          note_en <= sw;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (w_start_edge && !stop) begin
            r_mode   <= mode;
            r_dur    <= dur_sel;
            r_sw     <= sw;
            r_pos    <= 4'd0;
            r_ticks  <= 3'd0;
            r_gap    <= '0;
            note_idx <= w_first_idx;
            note_en  <= onehot(w_first_idx) & sw;
            busy     <= 1'b1;
            r_state  <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (stop) begin
            note_en <= 8'h00;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_note_end) begin
            r_ticks <= 3'd0;
            if (w_last) begin
              note_en <= 8'h00;
              done    <= 1'b1;
              r_state <= ST_DONE;
            end else if (GAP_CYCLES > 0) begin
              note_en <= 8'h00;
              r_gap   <= '0;
              r_state <= ST_GAP;
            end else begin
              r_pos    <= w_next_pos;
              note_idx <= w_next_idx;
              note_en  <= onehot(w_next_idx) & r_sw;
            end
          end else if (w_tick) begin
            r_ticks <= r_ticks + 3'd1;
          end
        end
        ST_GAP: begin
          if (stop) begin
            note_en <= 8'h00;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_gap == C_GAP_LAST) begin
            r_pos    <= w_next_pos;
            note_idx <= w_next_idx;
            note_en  <= onehot(w_next_idx) & r_sw;
            r_state  <= ST_PLAY;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          note_en <= sw;
          r_state <= ST_IDLE;
        end
        default: begin
          note_en <= 8'h00;
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_note_sequencer                                          |
// | Description : Scoreboard bench, one sequencer with and one without gaps. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_note_sequencer;

  localparam int CLK_HZ   = 16;
  localparam int BEAT_HZ  = 1;
  localparam int TICK_DIV = 4;
  localparam int GAP_B    = 2;

  typedef struct {
    int         cyc;
    logic [7:0] en;
    logic [2:0] idx;
    logic       idx_chk;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] sw;
  logic [1:0] mode, dur_sel;

  logic [7:0] en_a, en_b;
  logic [2:0] idx_a, idx_b;
  logic       busy_a, busy_b, done_a, done_b;

  note_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .sw(sw), .start(start), .stop(stop), .mode(mode),
    .dur_sel(dur_sel), .note_en(en_a), .note_idx(idx_a), .busy(busy_a), .done(done_a)
  );

  note_sequencer #(.CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .sw(sw), .start(start), .stop(stop), .mode(mode),
    .dur_sel(dur_sel), .note_en(en_b), .note_idx(idx_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: per-DUT list of expected outputs for every remaining cycle of a sequence.
  exp_t plan [2][0:511];
  int   plan_len [2];
  int   plan_rd  [2];
  bit   in_done  [2];
  exp_t sbq_a [$];
  exp_t sbq_b [$];
  logic prev_start;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t mk(input logic [7:0] en, input logic [2:0] idx,
                              input logic chk, input logic b, input logic dn);
    exp_t e;
    e.cyc = 0; e.en = en; e.idx = idx; e.idx_chk = chk; e.busy = b; e.done = dn;
    return e;
  endfunction

  task automatic push_plan(input int d, input exp_t e);
    plan[d][plan_len[d]] = e;
    plan_len[d] = plan_len[d] + 1;
  endtask

  task automatic build_plan(input int d);
    int notes[$];
    int len, gap;
    gap = (d == 0) ? 0 : GAP_B;
    case (mode)
      2'b01: for (int i = 7; i >= 0; i--) notes.push_back(i);
      2'b10: begin
        for (int i = 0; i < 8; i++) notes.push_back(i);
        for (int i = 6; i >= 0; i--) notes.push_back(i);
      end
      default: for (int i = 0; i < 8; i++) notes.push_back(i);
    endcase
    len = TICK_DIV * ((dur_sel == 2'b00) ? 4 : (dur_sel == 2'b01) ? 2 : 1);
    plan_len[d] = 0;
    plan_rd[d]  = 0;
    foreach (notes[k]) begin
      for (int c = 0; c < len; c++)
        push_plan(d, mk(8'(8'h80 >> notes[k]) & sw, 3'(notes[k]), 1'b1, 1'b1, 1'b0));
      if (k != notes.size() - 1)
        for (int g = 0; g < gap; g++) push_plan(d, mk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0));
    end
    push_plan(d, mk(8'h00, 3'd0, 1'b0, 1'b1, 1'b1));
  endtask

  task automatic model_step(input int d);
    exp_t e;
    e = mk(sw, 3'd0, 1'b0, 1'b0, 1'b0);
    if (rst) begin
      e.en = 8'h00; e.idx_chk = 1'b1;
      plan_len[d] = 0; plan_rd[d] = 0; in_done[d] = 1'b0;
    end else if (in_done[d]) begin
      in_done[d] = 1'b0;
    end else if (plan_rd[d] < plan_len[d]) begin
      if (stop) begin
        e.en = 8'h00;
        plan_len[d] = 0; plan_rd[d] = 0;
      end else begin
        e = plan[d][plan_rd[d]];
        plan_rd[d] = plan_rd[d] + 1;
        in_done[d] = e.done;
      end
    end else if (start && !prev_start && !stop) begin
      build_plan(d);
      e = plan[d][0];
      plan_rd[d] = 1;
    end
    e.cyc = cyc + 1;
    if (d == 0) sbq_a.push_back(e);
    else        sbq_b.push_back(e);
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    prev_start = rst ? 1'b0 : start;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cmp(input string who, input string name, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s.%s cycle %0d: got %0h expected %0h", who, name, c, act, exp);
  endtask

  task automatic check(input string who, input exp_t e, input logic [7:0] en,
                       input logic [2:0] idx, input logic b, input logic dn);
    cmp(who, "note_en", e.cyc, 32'(en), 32'(e.en));
    cmp(who, "busy",    e.cyc, 32'(b),  32'(e.busy));
    cmp(who, "done",    e.cyc, 32'(dn), 32'(e.done));
    if (e.idx_chk) cmp(who, "note_idx", e.cyc, 32'(idx), 32'(e.idx));
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    while (sbq_a.size() > 0 && sbq_a[0].cyc <= cyc) begin
      e = sbq_a.pop_front();
      check("gap0", e, en_a, idx_a, busy_a, done_a);
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    while (sbq_b.size() > 0 && sbq_b[0].cyc <= cyc) begin
      e = sbq_b.pop_front();
      check("gap2", e, en_b, idx_b, busy_b, done_b);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; sw = 8'h00; mode = 2'b00; dur_sel = 2'b00;
    prev_start = 1'b0;
    plan_len[0] = 0; plan_len[1] = 0; plan_rd[0] = 0; plan_rd[1] = 0;
    in_done[0] = 1'b0; in_done[1] = 1'b0;
    run(3);
    rst = 1'b0; sw = 8'hA5; run(3);

    // up, quarter, full mask
    sw = 8'hFF; mode = 2'b00; dur_sel = 2'b10; start = 1'b1; run(1);
    start = 1'b0; sw = 8'h3C; mode = 2'b01; run(55);

    // down, full, upper half masked
    sw = 8'hF0; mode = 2'b01; dur_sel = 2'b00; start = 1'b1; run(1);
    start = 1'b0; run(150);

    // up-down, half; inputs wander mid-sequence while start stays high
    sw = 8'h5A; mode = 2'b10; dur_sel = 2'b01; start = 1'b1; run(1);
    for (int i = 0; i < 170; i++) begin
      sw = 8'($urandom); mode = 2'($urandom); dur_sel = 2'($urandom); run(1);
    end
    start = 1'b0; run(2);

    // stop during the third note, then restart
    sw = 8'hFF; mode = 2'b00; dur_sel = 2'b10; start = 1'b1; run(1);
    start = 1'b0; run(10);
    stop = 1'b1; run(1);
    stop = 1'b0; run(2);
    start = 1'b1; run(1);
    start = 1'b0; run(50);

    // start edge together with stop, then start held for 100 cycles twice
    start = 1'b1; stop = 1'b1; run(1);
    stop = 1'b0; run(100);
    start = 1'b0; run(1);
    start = 1'b1; run(100);
    start = 1'b0; run(5);

    // reset while the gapped instance sits in a gap
    sw = 8'hC3; mode = 2'b00; dur_sel = 2'b10; start = 1'b1; run(1);
    start = 1'b0; run(5);
    rst = 1'b1; run(1);
    rst = 1'b0; run(5);

    // sw = 0 sequence still completes
    sw = 8'h00; mode = 2'b01; dur_sel = 2'b10; start = 1'b1; run(1);
    start = 1'b0; run(50);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      stop = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) start = ~start;
      sw = 8'($urandom); mode = 2'($urandom); dur_sel = 2'($urandom);
      run(1);
    end

    rst = 1'b0; stop = 1'b0; start = 1'b0; run(3);
    @(negedge clk);
    #1;
    cmp("gap0", "drain", cyc, 32'(sbq_a.size()), 32'd0);
    cmp("gap2", "drain", cyc, 32'(sbq_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
